// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch block.
//   fetch_state_e  : fetch FSM encoding (IDLE / FETCH / HALT)
//   DEF_PC_SIZE    : default address/PC width
//   DEF_INSTR_SIZE : default instruction width
//   NOP            : value held in the instruction slot after reset
//   PERF_CNT_W     : width of the optional performance counters
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    localparam int unsigned DEF_PC_SIZE    = 32;
    localparam int unsigned DEF_INSTR_SIZE = 32;
    localparam int unsigned PERF_CNT_W     = 32;
    localparam logic [31:0] NOP            = 32'b0;

endpackage

// File: rtl/fetch_perf_counter.sv
// fetch_perf_counter: saturating event counter.
//   clk_i   : clock, rising edge
//   rst_ni  : synchronous active-low reset, clears the count
//   en_i    : count one event this cycle
//   count_o : current count, sticks at all-ones
module fetch_perf_counter
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = PERF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: sequences instruction fetch from a combinational,
// byte-addressed instruction memory into a one-entry valid/ready slot.
//
// Handshake: the slot (instr_o, instr_pc_o) is offered while
// instr_valid_o=1 and is consumed on any rising edge where
// instr_valid_o && instr_ready_i. The slot may be refilled on that same
// edge; while offered and not consumed, its contents are held stable.
//
// Ports:
//   clk_i, rst_ni        : clock / synchronous active-low reset
//   start_i              : leave IDLE and begin fetching
//   mem_pc_o             : memory address (the pc register itself)
//   mem_instr_i          : instruction at mem_pc_o (combinational)
//   mem_done_i           : no instruction at mem_pc_o (end of program)
//   redirect_i/_pc_i     : load a new pc, flush the slot, leave HALT
//   instr_o/instr_pc_o   : fetched instruction and its address
//   instr_valid_o        : slot valid
//   instr_ready_i        : decode consumes the slot
//   halted_o             : end of program reached
//   state_o              : FSM state, for observation
//   perf_fetched_o       : captures so far (FETCH_PERF_CNT_EN only)
//   perf_stall_o         : FETCH cycles stalled by decode (FETCH_PERF_CNT_EN only)
//
// Build option: define FETCH_PERF_CNT_EN to add the two saturating
// performance counters and their ports.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int unsigned          PC_SIZE    = DEF_PC_SIZE,
    parameter int unsigned          INSTR_SIZE = DEF_INSTR_SIZE,
    parameter logic [PC_SIZE-1:0]   RESET_PC   = '0,
    parameter int unsigned          PC_STEP    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    output logic [PC_SIZE-1:0]    mem_pc_o,
    input  logic [INSTR_SIZE-1:0] mem_instr_i,
    input  logic                  mem_done_i,
    input  logic                  redirect_i,
    input  logic [PC_SIZE-1:0]    redirect_pc_i,
    output logic [INSTR_SIZE-1:0] instr_o,
    output logic [PC_SIZE-1:0]    instr_pc_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic                  halted_o,
    output fetch_state_e          state_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_fetched_o,
    output logic [PERF_CNT_W-1:0] perf_stall_o
`endif
);

    fetch_state_e          state_q;
    logic [PC_SIZE-1:0]    pc_q;
    logic [INSTR_SIZE-1:0] instr_q;
    logic [PC_SIZE-1:0]    instr_pc_q;
    logic                  valid_q;
    logic                  halted_q;

    logic                  slot_free;
    logic [PC_SIZE-1:0]    pc_next_seq;
    logic                  capture;

    assign slot_free   = !valid_q || instr_ready_i;
    // Modulo 2^PC_SIZE; wrap past all-ones is intentional and silent.
    assign pc_next_seq = pc_q + PC_SIZE'(PC_STEP);
    // Redirect wins over everything, and a pending end-of-program only
    // takes effect once the slot can be freed.
    assign capture     = (state_q == ST_FETCH) && !redirect_i && slot_free && !mem_done_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= INSTR_SIZE'(NOP);
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (redirect_i) begin
                        pc_q <= redirect_pc_i;
                    end
                    if (start_i) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (redirect_i) begin
                        // Discard the slot even if decode is taking it now.
                        pc_q    <= redirect_pc_i;
                        valid_q <= 1'b0;
                    end else if (slot_free) begin
                        if (mem_done_i) begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                            valid_q  <= 1'b0;
                        end else begin
                            instr_q    <= mem_instr_i;
                            instr_pc_q <= pc_q;
                            valid_q    <= 1'b1;
                            pc_q       <= pc_next_seq;
                        end
                    end
                end
                ST_HALT: begin
                    if (redirect_i) begin
                        state_q  <= ST_FETCH;
                        pc_q     <= redirect_pc_i;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_pc_o      = pc_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = valid_q;
    assign halted_o      = halted_q;
    assign state_o       = state_q;

`ifdef FETCH_PERF_CNT_EN
    logic stall;
    assign stall = (state_q == ST_FETCH) && valid_q && !instr_ready_i;

    fetch_perf_counter #(.WIDTH(PERF_CNT_W)) u_perf_fetched (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (capture),
        .count_o (perf_fetched_o)
    );

    fetch_perf_counter #(.WIDTH(PERF_CNT_W)) u_perf_stall (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (stall),
        .count_o (perf_stall_o)
    );
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences instruction fetch from the combinational byte-addressed instruction memory: owns the program counter, drives the memory address, and registers each returned instruction into a one-entry valid/ready output slot for decode. It handles decode backpressure, branch/jump redirects with flush, and halts when the memory reports end-of-program. It sits between the instruction memory and the decode stage.

## Interface
- PC_SIZE, 32, address/PC width
- INSTR_SIZE, 32, instruction width
- RESET_PC, 0, PC loaded on reset
- PC_STEP, 4, PC increment per fetched instruction (bytes)

- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  reset; synchronous, active-low
- start_i  in  1  begin fetching (honoured in IDLE only)
- mem_pc_o  out  PC_SIZE  address to instruction memory; equals internal pc register
- mem_instr_i  in  INSTR_SIZE  instruction at mem_pc_o (combinational)
- mem_done_i  in  1  no instruction at mem_pc_o (end of program)
- redirect_i  in  1  load redirect_pc_i into pc and flush the output slot
- redirect_pc_i  in  PC_SIZE  redirect target
- instr_o  out  INSTR_SIZE  fetched instruction
- instr_pc_o  out  PC_SIZE  address of instr_o
- instr_valid_o  out  1  instr_o/instr_pc_o valid
- instr_ready_i  in  1  decode accepts the slot this cycle
- halted_o  out  1  end of program reached

## Operation
- Reset (rst_ni=0 at edge, any state, overrides everything): state=IDLE, pc=RESET_PC, instr_o=0, instr_pc_o=0, instr_valid_o=0, halted_o=0.
- States: IDLE, FETCH, HALT. Encoding is in the package.
- Slot free = !instr_valid_o || instr_ready_i.
- IDLE: start_i -> FETCH. No captures. redirect_i updates pc and stays IDLE.
- FETCH, per edge, in priority order:
  - redirect_i: pc<=redirect_pc_i, instr_valid_o<=0 (pending slot discarded even if ready), stay FETCH.
  - Slot free and mem_done_i: -> HALT, halted_o<=1, instr_valid_o<=0, pc unchanged.
  - Slot free and !mem_done_i: instr_o<=mem_instr_i, instr_pc_o<=pc, instr_valid_o<=1, pc<=pc+PC_STEP.
  - Slot not free: hold everything (instr_o, instr_pc_o and pc stable).
- HALT: halted_o=1, no fetch, instr_valid_o=0. start_i ignored. redirect_i -> FETCH, pc<=redirect_pc_i, halted_o<=0.
- PC arithmetic is modulo 2^PC_SIZE; wrap from all-ones region is silent. redirect_pc_i is used unmasked; alignment is the requester's responsibility.
- mem_instr_i is sampled only when mem_done_i=0.

## Timing
- Fetch latency 1 cycle: pc presented in cycle N -> on instr_o with instr_valid_o=1 in cycle N+1.
- Throughput one instruction per cycle while instr_ready_i=1.
- First instruction appears 2 edges after start_i is sampled: edge 1 enters FETCH, edge 2 captures.
- Redirect: one bubble cycle (valid=0), then target instruction on the following edge.
- halted_o rises on the edge that samples mem_done_i with the slot free.
- All outputs registered except mem_pc_o (direct from the pc register).

## Configuration
- FETCH_PERF_CNT_EN defined: adds ports perf_fetched_o (out, 32: count of captures) and perf_stall_o (out, 32: FETCH cycles with instr_valid_o && !instr_ready_i). Both are zeroed by reset and saturate at 0xFFFFFFFF.
- FETCH_PERF_CNT_EN undefined: ports and counters are absent; the rest of the behaviour is identical.

## Structure
- fetch_pkg: state enum (IDLE/FETCH/HALT), default PC_SIZE/INSTR_SIZE, NOP constant (32'b0), PERF_CNT_W=32.
- One sub-module, fetch_perf_counter (saturating counter with enable), instantiated twice under FETCH_PERF_CNT_EN.

## Test plan
- Reset, start_i=1 one cycle, memory 0x0=0x00500093, 0x4=0x00a00113, ready=1 -> edge 2: instr_o=0x00500093, instr_pc_o=0x0, valid=1; edge 3: 0x00a00113 at 0x4.
- With valid=1 at instr_pc_o=0x4, ready=0 for 3 cycles -> instr_o, instr_pc_o and mem_pc_o=0x8 are held; on ready=1, next edge captures pc 0x8.
- redirect_i=1 with redirect_pc_i=0x100 while slot holds pc 0x8 and ready=1 -> next cycle valid=0, mem_pc_o=0x100; following edge gives instr_pc_o=0x100.
- 3-word program, mem_done_i=1 at pc 0xC -> pc 0x8 is delivered, then halted_o=1, valid=0, pc stays 0xC; start_i ignored; redirect to 0x0 clears halted_o and resumes.
- rst_ni=0 for one edge while in FETCH with valid=1 -> all outputs at reset values, mem_pc_o=RESET_PC, state IDLE until start_i.
- FETCH_PERF_CNT_EN: run the backpressure scenario -> perf_stall_o=3, perf_fetched_o equals the number of captures; preload near saturation -> counter sticks at 0xFFFFFFFF.
